// File: rtl/fixed_div_pkg.sv
// Shared definitions for the fixed-point arithmetic units: default Q-format and FSM encoding.
package fixed_div_pkg;

  localparam int unsigned DefaultD = 8;
  localparam int unsigned DefaultQ = 24;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/fixed_div_sat_sign.sv
// Applies sign, divide-by-zero and saturation to an unsigned quotient magnitude.
module fixed_div_sat_sign
  import fixed_div_pkg::*;
#(
  parameter int unsigned D = DefaultD,
  parameter int unsigned Q = DefaultQ
) (
  input  logic [D+2*Q-1:0] i_q,
  input  logic             i_sign,
  input  logic             i_dz,
  input  logic             i_asign,
  output logic [D+Q-1:0]   o_res
);

  localparam int unsigned W  = D + Q;
  localparam int unsigned NW = D + 2 * Q;

  localparam logic [W-1:0]  FixedMax = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  FixedMin = {1'b1, {(W-1){1'b0}}};
  // Largest representable magnitudes for positive and negative results.
  localparam logic [NW-1:0] MaxPos   = {{(Q+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [NW-1:0] MaxNeg   = {{Q{1'b0}}, 1'b1, {(W-1){1'b0}}};

  always_comb begin
    o_res = '0;
    if (i_dz) begin
      o_res = i_asign ? FixedMin : FixedMax;
    end else if (!i_sign) begin
      o_res = (i_q > MaxPos) ? FixedMax : i_q[W-1:0];
    end else begin
      o_res = (i_q > MaxNeg) ? FixedMin : (~i_q[W-1:0] + 1'b1);
    end
  end

endmodule

// File: rtl/fixed_div.sv
// Iterative signed QD.Q restoring divider, one quotient bit per cycle, fixed latency.
// Define FIXED_DIV_CE_EN to add a clock-enable input that freezes all state when low.
module fixed_div
  import fixed_div_pkg::*;
#(
  parameter int unsigned D = DefaultD,
  parameter int unsigned Q = DefaultQ
) (
  input  logic           clk,
  input  logic           rst,
`ifdef FIXED_DIV_CE_EN
  input  logic           ce,
`endif
  input  logic           new_data,
  output logic           ready,
  input  logic [D+Q-1:0] a,
  input  logic [D+Q-1:0] b,
  output logic           output_valid,
  output logic [D+Q-1:0] r,
  output logic           div_by_zero
);

  localparam int unsigned W    = D + Q;
  localparam int unsigned NW   = D + 2 * Q;
  localparam int unsigned CntW = $clog2(NW + 1);

  logic            w_ce;
  state_e          r_state, w_state_next;
  logic [CntW-1:0] r_cnt;
  logic [NW-1:0]   r_num;
  logic [W-1:0]    r_rem, r_bmag;
  logic            r_sign, r_asign, r_dz;
  logic [W-1:0]    r_res;
  logic            r_valid, r_dz_out;

  logic [W-1:0]    w_amag, w_bmag, w_rem_diff, w_rem_next, w_sat;
  logic [W:0]      w_rem_sh;
  logic            w_ge;

`ifdef FIXED_DIV_CE_EN
  assign w_ce = ce;
`else
  assign w_ce = 1'b1;
`endif

  // Magnitudes are unsigned W bits, so |MIN| is exact.
  assign w_amag = a[W-1] ? (~a + 1'b1) : a;
  assign w_bmag = b[W-1] ? (~b + 1'b1) : b;

  // Remainder stays below |b| <= 2^(W-1), so the difference fits in W bits.
  assign w_rem_sh   = {r_rem, r_num[NW-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_bmag});
  assign w_rem_diff = w_rem_sh[W-1:0] - r_bmag;
  assign w_rem_next = w_ge ? w_rem_diff : w_rem_sh[W-1:0];

  fixed_div_sat_sign #(
    .D (D),
    .Q (Q)
  ) u_sat (
    .i_q     (r_num),
    .i_sign  (r_sign),
    .i_dz    (r_dz),
    .i_asign (r_asign),
    .o_res   (w_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else if (w_ce) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (new_data) w_state_next = StCalc;
      StCalc:  if (r_cnt == CntW'(1)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_num    <= '0;
      r_rem    <= '0;
      r_bmag   <= '0;
      r_sign   <= 1'b0;
      r_asign  <= 1'b0;
      r_dz     <= 1'b0;
      r_res    <= '0;
      r_valid  <= 1'b0;
      r_dz_out <= 1'b0;
    end else if (w_ce) begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (new_data) begin
            r_sign  <= a[W-1] ^ b[W-1];
            r_asign <= a[W-1];
            r_dz    <= (b == '0);
            r_bmag  <= w_bmag;
            r_num   <= {w_amag, {Q{1'b0}}};
            r_rem   <= '0;
            r_cnt   <= CntW'(NW);
          end
        end
        StCalc: begin
          // Quotient bits shift into the numerator register as its bits are consumed.
          r_rem <= w_rem_next;
          r_num <= {r_num[NW-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        StDone: begin
          r_res    <= w_sat;
          r_dz_out <= r_dz;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready        = (r_state == StIdle);
  assign output_valid = r_valid;
  assign r            = r_res;
  assign div_by_zero  = r_dz_out;

endmodule

// File: tb/tb_fixed_div.sv
// Randomized self-checking bench for fixed_div against a latency/arithmetic reference model.
module tb_fixed_div;

  localparam int W   = 32;
  localparam int QB  = 24;
  localparam int LAT = 57;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tb_ce = 1'b1;
  logic        new_data = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        ready, output_valid, div_by_zero;
  logic [31:0] r;

  int n_pass = 0;
  int n_total = 0;

  fixed_div u_dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FIXED_DIV_CE_EN
    .ce           (tb_ce),
`endif
    .new_data     (new_data),
    .ready        (ready),
    .a            (a),
    .b            (b),
    .output_valid (output_valid),
    .r            (r),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Exact rational quotient truncated toward zero, then clamped to the Q8.24 range.
  function automatic logic [31:0] model_r(input logic [31:0] ia, input logic [31:0] ib);
    longint sa, sb, q;
    logic [63:0] qv;
    if (ib == 32'd0) return ia[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    sa = longint'($signed(ia));
    sb = longint'($signed(ib));
    q  = (sa * (64'sd1 <<< QB)) / sb;
    if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (q < -64'sd2147483648) return 32'h8000_0000;
    qv = q;
    return qv[31:0];
  endfunction

  // Reference model: busy for LAT enabled edges after an accept, then one result pulse.
  bit          m_busy = 0, m_ov = 0, m_dz = 0, m_pend_dz = 0;
  int          m_left = 0;
  logic [31:0] m_r = '0, m_pend_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_ov   <= 0;
      m_left <= 0;
      m_r    <= '0;
      m_dz   <= 0;
    end else if (tb_ce) begin
      m_ov <= 0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 0;
          m_ov   <= 1;
          m_r    <= m_pend_r;
          m_dz   <= m_pend_dz;
        end
        m_left <= m_left - 1;
      end else if (new_data) begin
        m_busy    <= 1;
        m_left    <= LAT;
        m_pend_r  <= model_r(a, b);
        m_pend_dz <= (b == 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(!m_busy));
    check("output_valid", 32'(output_valid), 32'(m_ov));
    check("r", r, m_r);
    check("div_by_zero", 32'(div_by_zero), 32'(m_dz));
  end

  task automatic start(input logic [31:0] ia, input logic [31:0] ib);
    a = ia;
    b = ib;
    new_data = 1'b1;
    @(posedge clk);
    #2 new_data = 1'b0;
  endtask

  task automatic wait_result(input int base, input logic [31:0] er, input bit edz, input int elat,
                             input string nm);
    int lat = -1;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      @(negedge clk);
      if (output_valid) lat = base + i;
    end
    check({nm, "_latency"}, 32'(lat), 32'(elat));
    check({nm, "_r"}, r, er);
    check({nm, "_dz"}, 32'(div_by_zero), 32'(edz));
  endtask

  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [31:0] er,
                        input bit edz, input string nm);
    @(posedge clk);
    #2 start(ia, ib);
    wait_result(0, er, edz, LAT, nm);
  endtask

  task automatic count_pulses(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (output_valid) cnt++;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 5))
      0: v = v >> $urandom_range(8, 31);
      1: v = 32'd0;
      2: v = 32'h8000_0000;
      3: v = -(v >> $urandom_range(8, 31));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    int pulses;
    logic [31:0] ra, rb;

    // Pin the reference model to hand-computed values.
    check("model_3_2", model_r(32'h0300_0000, 32'h0200_0000), 32'h0180_0000);
    check("model_m1_4", model_r(32'hFF00_0000, 32'h0400_0000), 32'hFFC0_0000);
    check("model_1_3", model_r(32'h0100_0000, 32'h0300_0000), 32'h0055_5555);
    check("model_100_half", model_r(32'h6400_0000, 32'h0080_0000), 32'h7FFF_FFFF);
    check("model_m128_m1", model_r(32'h8000_0000, 32'hFF00_0000), 32'h7FFF_FFFF);
    check("model_m128_half", model_r(32'h8000_0000, 32'h0080_0000), 32'h8000_0000);
    check("model_dz_pos", model_r(32'h0100_0000, 32'h0), 32'h7FFF_FFFF);
    check("model_dz_neg", model_r(32'hFF00_0000, 32'h0), 32'h8000_0000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_valid", 32'(output_valid), 32'd0);
    check("reset_r", r, 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    #1 rst = 1'b0;

    run_op(32'h0300_0000, 32'h0200_0000, 32'h0180_0000, 0, "div_3_2");
    run_op(32'hFF00_0000, 32'h0400_0000, 32'hFFC0_0000, 0, "div_m1_4");
    // Accept on the first ready cycle after a pulse.
    start(32'h0100_0000, 32'h0300_0000);
    wait_result(0, 32'h0055_5555, 0, LAT, "b2b_1_3");
    run_op(32'h6400_0000, 32'h0080_0000, 32'h7FFF_FFFF, 0, "sat_100_half");
    run_op(32'h8000_0000, 32'hFF00_0000, 32'h7FFF_FFFF, 0, "sat_m128_m1");
    run_op(32'h8000_0000, 32'h0080_0000, 32'h8000_0000, 0, "sat_m128_half");
    run_op(32'h0100_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1, "dz_pos");
    run_op(32'hFF00_0000, 32'h0000_0000, 32'h8000_0000, 1, "dz_neg");
    run_op(32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1, "dz_zero");

    // Second new_data while busy must be ignored.
    @(posedge clk);
    #2 start(32'h0300_0000, 32'h0200_0000);
    repeat (10) @(posedge clk);
    #2 a = 32'h0100_0000;
    b = 32'h0300_0000;
    new_data = 1'b1;
    @(posedge clk);
    #2 new_data = 1'b0;
    wait_result(11, 32'h0180_0000, 0, LAT, "ignored_2nd");
    count_pulses(70, pulses);
    check("ignored_extra_pulses", 32'(pulses), 32'd0);

    // Reset mid-operation abandons the division.
    @(posedge clk);
    #2 start(32'h0100_0000, 32'h0300_0000);
    repeat (19) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(output_valid), 32'd0);
    check("midrst_r", r, 32'd0);
    check("midrst_dz", 32'(div_by_zero), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    count_pulses(80, pulses);
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    run_op(32'hFF00_0000, 32'h0400_0000, 32'hFFC0_0000, 0, "after_rst");

`ifdef FIXED_DIV_CE_EN
    @(posedge clk);
    #2 start(32'h0300_0000, 32'h0200_0000);
    repeat (20) @(posedge clk);
    #2 tb_ce = 1'b0;
    repeat (10) @(posedge clk);
    #2 tb_ce = 1'b1;
    wait_result(30, 32'h0180_0000, 0, LAT + 10, "ce_stall");
`endif

    for (int i = 0; i < 30; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      run_op(ra, rb, model_r(ra, rb), (rb == 32'd0), "rand_op");
    end

    // Free-running random traffic; the compare process checks every cycle.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2 a = rnd_op();
      b = rnd_op();
      new_data = ($urandom_range(0, 3) == 0);
`ifdef FIXED_DIV_CE_EN
      tb_ce = ($urandom_range(0, 4) != 0);
`endif
    end
    @(posedge clk);
    #2 new_data = 1'b0;
    tb_ce = 1'b1;
    repeat (80) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
